// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI mode-3 serializer among NUM_REQ driver chips.
// Each grant runs one full-duplex SIZE-bit transfer: CS setup, MSB-first shift, CS hold, done pulse.
module spi_xfer_arbiter #(
  parameter int unsigned SIZE     = 40,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*SIZE-1:0]   data_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [SIZE-1:0]           data_out,
  output logic [NUM_REQ-1:0]        cs_n_out,
  output logic                      sclk_out,
  output logic                      mosi_out,
  input  logic                      miso_in
);

  localparam int unsigned SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BIT_W    = $clog2(SIZE + 1);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SIZE-1:0]    tx_q, tx_d;
  logic [SIZE-1:0]    rx_q, rx_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               hi_q, hi_d;

  logic [NUM_REQ-1:0] gnt_d;
  logic               busy_d;
  logic               done_d;
  logic [SIZE-1:0]    data_d;
  logic [NUM_REQ-1:0] cs_d;
  logic               sclk_d;
  logic               mosi_d;

  logic               found;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   cand;
  logic [SIZE-1:0]    tx_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign tx_words[g] = data_in[g*SIZE +: SIZE];
  end

  // First requester after the last granted index, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = SEL_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && req_in[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs are registered one cycle after the state that drives them
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    div_d   = div_q;
    wait_d  = wait_q;
    hi_d    = hi_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    data_d  = data_out;
    cs_d    = '1;
    sclk_d  = 1'b1;
    mosi_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          sel_d      = win;
          last_d     = win;
          tx_d       = tx_words[win];
          wait_d     = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cs_d[sel_q] = 1'b0;
        busy_d      = 1'b1;
        mosi_d      = tx_q[SIZE-1];
        if (wait_q == WAIT_W'(CS_SETUP - 1)) begin
          div_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_SHIFT: begin
        cs_d[sel_q] = 1'b0;
        busy_d      = 1'b1;
        sclk_d      = hi_q;
        mosi_d      = tx_q[SIZE-1];
        // Capture on the edge that raises sclk_out
        if (hi_q && (div_q == '0)) begin
          rx_d = {rx_q[SIZE-2:0], miso_in};
        end
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            hi_d = 1'b0;
            tx_d = {tx_q[SIZE-2:0], 1'b0};
            if (bit_q == BIT_W'(SIZE - 1)) begin
              wait_d  = '0;
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        cs_d[sel_q] = 1'b0;
        busy_d      = 1'b1;
        mosi_d      = mosi_out;
        if (wait_q == WAIT_W'(CS_HOLD - 1)) begin
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        data_d  = rx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      last_q   <= SEL_W'(NUM_REQ - 1);
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      wait_q   <= '0;
      hi_q     <= 1'b0;
      gnt_out  <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      data_out <= '0;
      cs_n_out <= '1;
      sclk_out <= 1'b1;
      mosi_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      wait_q   <= wait_d;
      hi_q     <= hi_d;
      gnt_out  <= gnt_d;
      busy_out <= busy_d;
      done_out <= done_d;
      data_out <= data_d;
      cs_n_out <= cs_d;
      sclk_out <= sclk_d;
      mosi_out <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: expected grants and received words are queued at issue time,
// and a monitor checks them, together with per-transfer timing, whenever the DUT pulses gnt_out or done_out.
module tb_spi_xfer_arbiter;

  typedef struct {
    logic        idx;
    logic [39:0] tx;
    bit          gap;
  } gexp_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [1:0]  req_in;
  logic [79:0] data_in;
  logic [1:0]  gnt_out;
  logic        busy_out, done_out;
  logic [39:0] data_out;
  logic [1:0]  cs_n_out;
  logic        sclk_out, mosi_out, miso_w;

  logic [1:0]  req1;
  logic [79:0] dat1;
  logic [1:0]  g1, cs1;
  logic        b1, dn1, sc1, mo1;
  logic [39:0] do1;

  logic        lb_mode;
  logic        pat_bit;
  logic [39:0] pat_word, pat_sh;

  int checks = 0;
  int errors = 0;
  int cyc = 0, g_cyc = 0, done_cyc = 0;
  int rises = 0, cs_low = 0, busy_cnt = 0, hi_run = 100;
  logic        both_low, sclk_prev;
  logic [39:0] mosi_word, cur_tx;

  gexp_t       exp_g [$];
  logic [39:0] exp_d [$];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  assign miso_w = lb_mode ? mosi_out : pat_bit;

  spi_xfer_arbiter #(.SIZE(40), .NUM_REQ(2), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
    .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in), .data_in(data_in),
    .gnt_out(gnt_out), .busy_out(busy_out), .done_out(done_out), .data_out(data_out),
    .cs_n_out(cs_n_out), .sclk_out(sclk_out), .mosi_out(mosi_out), .miso_in(miso_w)
  );

  spi_xfer_arbiter #(.SIZE(40), .NUM_REQ(2), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut1 (
    .clk_in(clk_in), .reset_in(reset_in), .req_in(req1), .data_in(dat1),
    .gnt_out(g1), .busy_out(b1), .done_out(dn1), .data_out(do1),
    .cs_n_out(cs1), .sclk_out(sc1), .mosi_out(mo1), .miso_in(mo1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic idx, input logic [39:0] tx, input bit gap, input logic [39:0] rx);
    gexp_t e;
    e.idx = idx; e.tx = tx; e.gap = gap;
    exp_g.push_back(e);
    exp_d.push_back(rx);
  endtask

  // Raise one request, hold it until granted, then drop it
  task automatic req_once(input logic idx, input logic [39:0] d);
    int n = 0;
    if (idx) data_in[79:40] = d; else data_in[39:0] = d;
    req_in[idx] = 1'b1;
    do begin
      @(negedge clk_in);
      n++;
    end while (!gnt_out[idx] && n < 3000);
    if (!gnt_out[idx]) chk("grant_timeout", 64'(gnt_out[idx]), 64'd1);
    req_in[idx] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_d.size() != 0 || exp_g.size() != 0) && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    chk("drain", 64'(exp_d.size() + exp_g.size()), 64'd0);
    repeat (3) @(negedge clk_in);
  endtask

  // MISO pattern driver: next bit MSB-first on each sclk fall
  initial begin
    logic sp;
    sp = 1'b1;
    pat_bit = 1'b0;
    pat_sh = '0;
    forever begin
      @(negedge clk_in);
      if (gnt_out != 2'b00) pat_sh = pat_word;
      if (sp && !sclk_out && cs_n_out != 2'b11) begin
        pat_bit = pat_sh[39];
        pat_sh  = {pat_sh[38:0], 1'b0};
      end
      sp = sclk_out;
    end
  end

  // Monitor: per-cycle bookkeeping plus scoreboard pops on gnt_out / done_out
  initial begin
    gexp_t e;
    logic [39:0] rx;
    both_low = 1'b0;
    sclk_prev = 1'b1;
    mosi_word = '0;
    cur_tx = '0;
    forever begin
      @(negedge clk_in);
      if (cs_n_out == 2'b00) both_low = 1'b1;
      if (cs_n_out != 2'b11) begin
        if (hi_run != 0) chk("cs_gap_ge2", 64'(hi_run >= 2), 64'd1);
        hi_run = 0;
        cs_low++;
      end else begin
        hi_run++;
      end
      if (busy_out) busy_cnt++;
      if (sclk_out && !sclk_prev && cs_n_out != 2'b11) begin
        rises++;
        mosi_word = {mosi_word[38:0], mosi_out};
      end
      sclk_prev = sclk_out;
      if (gnt_out != 2'b00) begin
        if (exp_g.size() == 0) begin
          chk("unexpected_grant", 64'(gnt_out), 64'd0);
        end else begin
          e = exp_g.pop_front();
          chk("grant_onehot", 64'(gnt_out), e.idx ? 64'd2 : 64'd1);
          if (e.gap) chk("grant_after_done", 64'(cyc - done_cyc), 64'd1);
          cur_tx = e.tx;
        end
        g_cyc = cyc; rises = 0; cs_low = 0; busy_cnt = 0; mosi_word = '0; both_low = 1'b0;
      end
      if (done_out) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_done", 64'(done_out), 64'd0);
        end else begin
          rx = exp_d.pop_front();
          chk("rx_data", 64'(data_out), 64'(rx));
          chk("gnt_to_done", 64'(cyc - g_cyc), 64'd165);
          chk("sclk_rises", 64'(rises), 64'd40);
          chk("cs_low_cycles", 64'(cs_low), 64'd164);
          chk("busy_cycles", 64'(busy_cnt), 64'd164);
          chk("mosi_msb_first", 64'(mosi_word), 64'(cur_tx));
          chk("one_cs_low", 64'(both_low), 64'd0);
          chk("busy_at_done", 64'(busy_out), 64'd0);
        end
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g_at, lows, r;
    logic sp;
    reset_in = 1'b1; req_in = '0; data_in = '0; req1 = '0; dat1 = '0;
    lb_mode = 1'b1; pat_word = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_gnt",  64'(gnt_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_cs",   64'(cs_n_out), 64'd3);
    chk("rst_sclk", 64'(sclk_out), 64'd1);
    chk("rst_mosi", 64'(mosi_out), 64'd0);
    reset_in = 1'b0;

    // Single loopback transfer on requester 0
    push(1'b0, 40'hA5_1234_5678, 1'b0, 40'hA5_1234_5678);
    req_once(1'b0, 40'hA5_1234_5678);
    drain();

    // MISO capture from a driven pattern on requester 1
    lb_mode = 1'b0;
    pat_word = 40'h00_FFFF_0000;
    push(1'b1, 40'h5A_C3C3_0F0F, 1'b0, 40'h00_FFFF_0000);
    req_once(1'b1, 40'h5A_C3C3_0F0F);
    drain();
    lb_mode = 1'b1;

    // Contention: both held, grants alternate 0,1,0,1
    push(1'b0, 40'h11_2233_4455, 1'b0, 40'h11_2233_4455);
    push(1'b1, 40'h80_0000_0001, 1'b1, 40'h80_0000_0001);
    push(1'b0, 40'hFF_0000_FFFF, 1'b1, 40'hFF_0000_FFFF);
    push(1'b1, 40'h0F_F0F0_0F0F, 1'b1, 40'h0F_F0F0_0F0F);
    fork
      begin req_once(1'b0, 40'h11_2233_4455); req_once(1'b0, 40'hFF_0000_FFFF); end
      begin req_once(1'b1, 40'h80_0000_0001); req_once(1'b1, 40'h0F_F0F0_0F0F); end
    join
    drain();

    // Late request from 1 during a transfer of 0
    push(1'b0, 40'hDE_ADBE_EF01, 1'b0, 40'hDE_ADBE_EF01);
    push(1'b1, 40'h12_3456_789A, 1'b1, 40'h12_3456_789A);
    fork
      req_once(1'b0, 40'hDE_ADBE_EF01);
      begin repeat (60) @(negedge clk_in); req_once(1'b1, 40'h12_3456_789A); end
    join
    drain();

    // Reset around bit 20 of SHIFT; pointer must restart at index 0
    exp_g.push_back('{idx: 1'b0, tx: 40'hCA_FEBA_BE00, gap: 1'b0});
    req_once(1'b0, 40'hCA_FEBA_BE00);
    n = 0;
    do begin @(negedge clk_in); n++; end while (rises < 20 && n < 1000);
    chk("reach_bit20", 64'(rises >= 20), 64'd1);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("abort_cs",   64'(cs_n_out), 64'd3);
    chk("abort_sclk", 64'(sclk_out), 64'd1);
    chk("abort_busy", 64'(busy_out), 64'd0);
    chk("abort_data", 64'(data_out), 64'd0);
    chk("abort_done", 64'(done_out), 64'd0);
    reset_in = 1'b0;
    push(1'b0, 40'h01_0203_0405, 1'b0, 40'h01_0203_0405);
    push(1'b1, 40'hF0_E0D0_C0B0, 1'b1, 40'hF0_E0D0_C0B0);
    fork
      req_once(1'b0, 40'h01_0203_0405);
      req_once(1'b1, 40'hF0_E0D0_C0B0);
    join
    drain();

    // CLK_DIV=1 instance: single loopback transfer
    req1 = 2'b01;
    dat1[39:0] = 40'h3C_0F1E_2D4B;
    n = 0;
    do begin @(negedge clk_in); n++; end while (!g1[0] && n < 100);
    chk("d1_gnt", 64'(g1), 64'd1);
    g_at = cyc;
    req1 = 2'b00;
    lows = 0; r = 0; sp = 1'b1; n = 0;
    do begin
      @(negedge clk_in);
      n++;
      if (cs1 != 2'b11) begin
        if (!sc1) lows++;
        if (sc1 && !sp) r++;
      end
      sp = sc1;
    end while (!dn1 && n < 300);
    chk("d1_done_seen", 64'(dn1), 64'd1);
    chk("d1_gnt_to_done", 64'(cyc - g_at), 64'd85);
    chk("d1_rx_data", 64'(do1), 64'h3C_0F1E_2D4B);
    chk("d1_sclk_low_cycles", 64'(lows), 64'd40);
    chk("d1_sclk_rises", 64'(r), 64'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Shares one SPI serializer among NUM_REQ requesters (one stepper driver chip each) and sequences complete SIZE-bit full-duplex transfers. The block grants requesters round-robin, drives the per-chip chip select, SCLK and MOSI, and captures MISO into a receive word. It sits between the motion/config logic and the driver-chip pins.

## Interface
- SIZE, 40: bits per transfer (datagram width).
- NUM_REQ, 2: number of requesters / chip selects, ≥1.
- CLK_DIV, 4: clk_in cycles per SCLK half-period, ≥1.
- CS_SETUP, 2: cycles with CS low before the first SCLK fall, ≥1.
- CS_HOLD, 2: cycles with CS low after the last SCLK rise, ≥1.
- clk_in  in  1  system clock; all logic on its rising edge.
- reset_in  in  1  synchronous, active-high reset.
- req_in  in  NUM_REQ  per-requester transfer request (level).
- data_in  in  NUM_REQ*SIZE  TX words; requester i at bits [i*SIZE +: SIZE].
- gnt_out  out  NUM_REQ  one-hot, one-cycle grant pulse.
- busy_out  out  1  high while a transfer is in progress.
- done_out  out  1  one-cycle pulse when a transfer completes.
- data_out  out  SIZE  last received word; holds until the next done_out.
- cs_n_out  out  NUM_REQ  active-low chip selects.
- sclk_out  out  1  SPI clock, mode 3 (idle high).
- mosi_out  out  1  serial data out, MSB first.
- miso_in  in  1  serial data in.

## Operation
- All outputs are registered. Reset values: gnt_out=0, busy_out=0, done_out=0, data_out=0, cs_n_out=all 1, sclk_out=1, mosi_out=0. The round-robin pointer resets so that index 0 wins first.
- States:
  - IDLE: if any req_in bit is set, pick the first set index after the last granted index, with wrap-around. Pulse gnt_out for that index, latch its data_in slice into the shift register, record the index, and go to SETUP. With no request, stay in IDLE.
  - SETUP: lasts CS_SETUP cycles. cs_n_out[sel]=0, sclk_out=1, mosi_out=TX bit SIZE-1, busy_out=1.
  - SHIFT: lasts SIZE bit periods of 2*CLK_DIV cycles each. Each period has sclk_out low for CLK_DIV cycles, then high for CLK_DIV cycles. mosi_out updates to the current bit on the cycle sclk_out falls. miso_in is sampled and shifted into the RX register on the cycle sclk_out rises.
  - HOLD: lasts CS_HOLD cycles. sclk_out=1, CS remains low.
  - DONE: lasts 1 cycle. All cs_n_out are high, done_out=1, data_out=RX register, busy_out=0. Always returns to IDLE; no grant is issued in this cycle.
- Requesters must hold req_in until they see gnt_out. req_in and data_in are ignored outside the grant cycle.
- Requests arriving during a transfer wait. The winner is granted in the IDLE cycle right after DONE.
- At most one cs_n_out bit is ever low.
- Bit counter width is $clog2(SIZE+1); divider counter width is $clog2(CLK_DIV), minimum 1 bit.
- Reset in any state returns to IDLE with reset output values on the next cycle. An aborted transfer produces no done_out, and data_out is cleared.

## Timing
- Grant at cycle G. SETUP occupies G+1..G+CS_SETUP.
- First SCLK fall is at G+CS_SETUP+1.
- done_out is at G+CS_SETUP+2*CLK_DIV*SIZE+CS_HOLD+1.
- CS is low for exactly CS_SETUP+2*CLK_DIV*SIZE+CS_HOLD cycles.
- Back-to-back transfers have minimum CS-high time of 1 cycle (DONE), plus 1 IDLE cycle before the next CS assertion.
- Exactly SIZE rising edges of sclk_out per transfer.

## Test plan
Parameters: SIZE=40, NUM_REQ=2, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2 (grant-to-done = 165 cycles) unless noted.
- Single transfer, loopback: req0 with data 40'hA5_1234_5678, miso_in tied to mosi_out -> gnt_out=2'b01 for 1 cycle; cs_n_out=2'b10 for 164 cycles; 40 SCLK rises; MOSI MSB-first; done_out 165 cycles after grant; data_out=40'hA5_1234_5678.
- MISO capture: bench drives 40'h00_FFFF_0000 MSB-first, changing on SCLK falls -> data_out=40'h00_FFFF_0000 at done_out.
- Contention: req0 and req1 both held high -> grants alternate 0,1,0,1; cs_n_out never 2'b00; at least 1 cycle of 2'b11 between transfers.
- Late request: req1 rises mid-transfer of 0 -> no grant until after done_out; gnt_out=2'b10 exactly 1 cycle after done_out.
- Reset at bit 20 of SHIFT -> next cycle cs_n_out=2'b11, sclk_out=1, busy_out=0, data_out=0, no done_out; a following req0 is granted index 0 and completes normally.
- CLK_DIV=1: sclk_out toggles every cycle during SHIFT; grant-to-done = 85 cycles; loopback data matches.
